// File: rtl/nand_cone_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_cone_bist_pkg
// Description : Shared types, default polynomials and the Galois step used by
//               the NAND-cone BIST wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_cone_bist_pkg;

    localparam int          C_GALOIS_MAX_W     = 64;
    localparam logic [15:0] C_DEFAULT_LFSR_POLY = 16'hB400;
    localparam logic [15:0] C_DEFAULT_MISR_POLY = 16'hB400;
    localparam logic [15:0] C_DEFAULT_SEED      = 16'h0001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Right-shifting Galois step; callers zero-extend narrower registers and
    // truncate the result back to their own width.
    function automatic logic [C_GALOIS_MAX_W-1:0] galois_step(
        input logic [C_GALOIS_MAX_W-1:0] s,
        input logic [C_GALOIS_MAX_W-1:0] poly
    );
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_cone_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : nand_cone_bist_if
// Description : Control, functional and status bundle of the NAND-cone BIST
//               block. Scan pins exist only when MISR_SCAN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nand_cone_bist_if #(
    parameter int CH     = 4,
    parameter int MISR_W = 16
);
    logic              start;
    logic [MISR_W-1:0] golden;
    logic [4*CH-1:0]   func_in;
    logic [CH-1:0]     func_out;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_pass;
    logic [MISR_W-1:0] signature;
`ifdef MISR_SCAN_EN
    logic              scan_en;
    logic              scan_in;
    logic              scan_out;
`endif

    modport master (
`ifdef MISR_SCAN_EN
        output scan_en,
        output scan_in,
        input  scan_out,
`endif
        output start,
        output golden,
        output func_in,
        input  func_out,
        input  bist_busy,
        input  bist_done,
        input  bist_pass,
        input  signature
    );

    modport slave (
`ifdef MISR_SCAN_EN
        input  scan_en,
        input  scan_in,
        output scan_out,
`endif
        input  start,
        input  golden,
        input  func_in,
        output func_out,
        output bist_busy,
        output bist_done,
        output bist_pass,
        output signature
    );
endinterface
`default_nettype wire

// File: rtl/nand_cone_slice.sv
`default_nettype none
// ============================================================================
// Module      : nand_cone_slice
// Description : One combinational 4-input, 8-NAND cone of the circuit under
//               test.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_cone_slice (
    input  wire logic [3:0] i_abcd,
    output logic            o_y
);
    logic w_a, w_b, w_c, w_d;
    logic w_t1, w_t2, w_t3;
    logic w_u1, w_u2, w_u3, w_u4;

    assign w_a  = i_abcd[0];
    assign w_b  = i_abcd[1];
    assign w_c  = i_abcd[2];
    assign w_d  = i_abcd[3];

    assign w_t1 = ~(w_a & w_c);
    assign w_t2 = ~(w_b & w_c);
    assign w_t3 = ~(w_b & w_d);

    assign w_u1 = ~(w_b  & w_t1);
    assign w_u2 = ~(w_a  & w_t2);
    assign w_u3 = ~(w_t2 & w_d);
    assign w_u4 = ~(w_t3 & w_c);

    assign o_y  = ~(w_u1 & w_u2 & w_u3 & w_u4);
endmodule
`default_nettype wire

// File: rtl/nand_cone_bist.sv
`default_nettype none
// ============================================================================
// Module      : nand_cone_bist
// Description : CH NAND cones with a pipe register, LFSR pattern source, MISR
//               compactor and BIST controller. Optional MISR scan access is
//               compiled in with `define MISR_SCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_cone_bist
    import nand_cone_bist_pkg::*;
#(
    parameter int                CH        = 4,
    parameter int                NPAT      = 255,
    parameter logic [4*CH-1:0]   LFSR_POLY = C_DEFAULT_LFSR_POLY,
    parameter logic [4*CH-1:0]   SEED      = C_DEFAULT_SEED,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = C_DEFAULT_MISR_POLY
) (
    input  wire logic       CK,
    input  wire logic       RST,
    nand_cone_bist_if.slave bus
);
    localparam int              C_IN_W    = 4 * CH;
    localparam logic [C_IN_W-1:0] C_SEED  = (SEED == '0) ? C_IN_W'(1) : SEED;
    localparam logic [15:0]     C_LAST_CNT = 16'(NPAT - 1);

    state_t              r_state_q, w_state_d;
    logic [C_IN_W-1:0]   r_lfsr_q,  w_lfsr_d;
    logic [MISR_W-1:0]   r_misr_q,  w_misr_d;
    logic [15:0]         r_cnt_q,   w_cnt_d;
    logic [CH-1:0]       r_pipe_q,  w_pipe_d;

    logic [C_IN_W-1:0]   w_cut_in;
    logic [CH-1:0]       w_cut_out;
    logic [C_IN_W-1:0]   w_lfsr_step;
    logic [MISR_W-1:0]   w_misr_step;

    assign w_cut_in = (r_state_q == S_RUN) ? r_lfsr_q : bus.func_in;

    for (genvar k = 0; k < CH; k++) begin : g_slice
        nand_cone_slice u_slice (
            .i_abcd (w_cut_in[4*k +: 4]),
            .o_y    (w_cut_out[k])
        );
    end

    assign w_pipe_d    = w_cut_out;
    assign w_lfsr_step = C_IN_W'(galois_step(C_GALOIS_MAX_W'(r_lfsr_q),
                                             C_GALOIS_MAX_W'(LFSR_POLY)));
    assign w_misr_step = MISR_W'(galois_step(C_GALOIS_MAX_W'(r_misr_q),
                                             C_GALOIS_MAX_W'(MISR_POLY)))
                       ^ MISR_W'(r_pipe_q);

    always_comb begin
        w_state_d = r_state_q;
        w_lfsr_d  = r_lfsr_q;
        w_misr_d  = r_misr_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_d = S_LOAD;
                end
`ifdef MISR_SCAN_EN
                else if (bus.scan_en) begin
                    w_misr_d = {bus.scan_in, r_misr_q[MISR_W-1:1]};
                end
`else
                // Signature is frozen here until the next start.
`endif
            end
            S_LOAD: begin
                w_lfsr_d  = C_SEED;
                w_misr_d  = '0;
                w_cnt_d   = '0;
                w_state_d = S_RUN;
            end
            S_RUN: begin
                w_lfsr_d = w_lfsr_step;
                w_cnt_d  = r_cnt_q + 16'd1;
                // First RUN cycle: the pipe still holds a functional response.
                if (r_cnt_q != 16'd0) begin
                    w_misr_d = w_misr_step;
                end
                if (r_cnt_q == C_LAST_CNT) begin
                    w_state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_misr_d  = w_misr_step;
                w_state_d = S_DONE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state_q <= S_IDLE;
            r_lfsr_q  <= C_SEED;
            r_misr_q  <= '0;
            r_cnt_q   <= '0;
            r_pipe_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_lfsr_q  <= w_lfsr_d;
            r_misr_q  <= w_misr_d;
            r_cnt_q   <= w_cnt_d;
            r_pipe_q  <= w_pipe_d;
        end
    end

    assign bus.func_out  = r_pipe_q;
    assign bus.bist_busy = (r_state_q == S_LOAD) || (r_state_q == S_RUN) ||
                           (r_state_q == S_DRAIN);
    assign bus.bist_done = (r_state_q == S_DONE);
    assign bus.bist_pass = (r_state_q == S_DONE) && (r_misr_q == bus.golden);
    assign bus.signature = r_misr_q;
`ifdef MISR_SCAN_EN
    assign bus.scan_out  = r_misr_q[0];
`endif

endmodule
`default_nettype wire
